serial_bls_sequencer: RTL and testbench
=======================================

Name: serial_bls_sequencer

Overview:
- Multi-cycle, nibble-serial subtractor controller computing Diff = X - Y - Bin on WIDTH-bit operands.
- Sequences one shared 4-bit borrow-lookahead subtractor (BLS) datapath, one nibble per clock, LSB nibble first.
- Holds the inter-nibble borrow in a register and reports result, borrow-out, zero and signed-overflow flags with a start/busy/done handshake.
- Sits between a requesting control FSM and the combinational 4-bit BLS.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 8.
- NIBBLES, WIDTH/4, derived local constant: number of RUN cycles. Not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- X  input  WIDTH  minuend; latched when start is accepted
- Y  input  WIDTH  subtrahend; latched when start is accepted
- Bin  input  1  borrow-in; latched when start is accepted
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when the result becomes valid
- Diff  output  WIDTH  result register
- Bout  output  1  final borrow-out
- zero  output  1  Diff == 0
- ovf  output  1  two's-complement overflow of X - Y - Bin

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, nibble counter=0, borrow reg=0, operand regs=0, Diff=0, Bout=0, zero=0, ovf=0, busy=0, done=0.
- Reset has priority over every other event, including mid-RUN. The operation in progress is discarded and no done pulse is produced.
- States:
  - IDLE: busy=0, done=0. start=1 → latch X, Y, Bin into regs (Bin goes to the borrow reg); counter=0; go to RUN.
  - RUN: busy=1. Each cycle, apply nibble [4*cnt+3:4*cnt] of the latched X and Y, plus the borrow reg, to the BLS. At the clock edge, write the BLS diff into the same Diff nibble and load BLS borrow-out into the borrow reg. cnt increments. When cnt==NIBBLES-1, go to DONE instead of incrementing.
  - DONE: done=1 for exactly one cycle; busy=0.
    - start=1 here → accepted exactly as in IDLE (back-to-back), next state RUN.
    - start=0 → next state IDLE.
- Latency: start high in cycle 0 → busy high in cycles 1..NIBBLES → done high in cycle NIBBLES+1 (5 for WIDTH=16). Throughput is one operation per NIBBLES+1 cycles.
- start in RUN is ignored. Latched operands are never modified mid-operation; X/Y/Bin may change freely after acceptance.
- Diff nibbles update progressively during RUN and are valid only from the done cycle onward.
- Diff, Bout, zero and ovf hold their values after done until the next accepted start. They are cleared to 0 on acceptance of the next start.
- Bout = borrow reg after the final nibble. Bout=1 iff unsigned X < Y + Bin.
- zero is registered with done: (Diff == 0) including the final nibble.
- ovf is registered with done: (X[W-1] ^ Y[W-1]) & (Diff[W-1] ^ X[W-1]), using the latched X and Y. This is correct including Bin.
- All arithmetic is modulo 2^WIDTH; there is no saturation.

Decomposition:
- Shared include/package holds:
  - state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2; value 2'd3 is illegal and recovers to IDLE;
  - the nibble width constant, 4.
- Exactly one sub-module: the team's existing combinational 4-bit BLS (Lab2_4_bit_BLS_behavioral), instantiated once and time-shared across nibbles.
- Counter, FSM and flag logic stay in the top module.

Test Plan:
- WIDTH=16, X=0x1234, Y=0x0FFF, Bin=0, start in cycle 0 → busy in cycles 1–4, done in cycle 5 only, Diff=0x0235, Bout=0, zero=0, ovf=0.
- X=0x0000, Y=0x0001, Bin=0 → Diff=0xFFFF, Bout=1, ovf=0. Separately, X=0x8000, Y=0x0001 → Diff=0x7FFF, Bout=0, ovf=1.
- X=Y=0x5A5A, Bin=0 → Diff=0x0000, zero=1, Bout=0. Repeat with Bin=1 → Diff=0xFFFF, zero=0, Bout=1.
- Start X=0x0010, Y=0x0001; in cycle 2 pulse start with X=0xFFFF, Y=0x0000 → second request ignored; Diff=0x000F at done.
- Assert rst in cycle 3 of RUN → next cycle busy=0, Diff=0, no done pulse. A fresh start then completes normally.
- Hold start high with new operands (0x0003 - 0x0004) during the done cycle → accepted back-to-back; second done 5 cycles later with Diff=0xFFFF, Bout=1.

Source files
------------

// File: rtl/serial_bls_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_bls_sequencer_pkg
//  Description : Shared state encoding and nibble width for the nibble-serial
//                borrow-lookahead subtraction sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_bls_sequencer_pkg;

    // Width of the shared subtractor slice; one slice is processed per clock.
    localparam int NIBBLE_W = 4;

    // Sequencer states. Encoding 2'd3 is unused and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : serial_bls_sequencer_pkg
`default_nettype wire

// File: rtl/serial_bls_sequencer_bls.sv
`default_nettype none
// ============================================================================
//  Module      : Lab2_4_bit_BLS_behavioral
//  Description : Combinational 4-bit borrow-lookahead subtractor computing
//                o_diff = i_a - i_b - i_bin with borrow-out o_bout.
//  Revision    : 1.0 - initial release
// ============================================================================
module Lab2_4_bit_BLS_behavioral
    import serial_bls_sequencer_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_a,
    input  logic [NIBBLE_W-1:0] i_b,
    input  logic                i_bin,
    output logic [NIBBLE_W-1:0] o_diff,
    output logic                o_bout
);

    // Borrow generate: bit position borrows regardless of incoming borrow.
    // Borrow propagate: bit position passes an incoming borrow through.
    logic [NIBBLE_W-1:0] w_g;
    logic [NIBBLE_W-1:0] w_p;
    logic [NIBBLE_W:0]   w_c;

    assign w_g = ~i_a & i_b;
    assign w_p = ~(i_a ^ i_b);

    // Flattened lookahead equations so every borrow is two levels deep.
    assign w_c[0] = i_bin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_bin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_bin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_bin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_bin);

    assign o_diff = i_a ^ i_b ^ w_c[NIBBLE_W-1:0];
    assign o_bout = w_c[NIBBLE_W];

endmodule : Lab2_4_bit_BLS_behavioral
`default_nettype wire

// File: rtl/serial_bls_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : serial_bls_sequencer
//  Description : Nibble-serial subtractor controller. Computes
//                Diff = X - Y - Bin one nibble per clock (LSB first) through a
//                single shared 4-bit borrow-lookahead subtractor, with
//                start/busy/done handshake and Bout/zero/ovf flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_bls_sequencer
    import serial_bls_sequencer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             zero,
    output logic             ovf
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int c_cnt_w = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(NIBBLES - 1);

    state_t               state_q,  state_d;
    logic [c_cnt_w-1:0]   cnt_q,    cnt_d;
    logic [WIDTH-1:0]     x_q,      x_d;
    logic [WIDTH-1:0]     y_q,      y_d;
    logic                 borrow_q, borrow_d;
    logic [WIDTH-1:0]     diff_q,   diff_d;
    logic                 bout_q,   bout_d;
    logic                 zero_q,   zero_d;
    logic                 ovf_q,    ovf_d;
    logic                 busy_q,   busy_d;
    logic                 done_q,   done_d;

    logic [NIBBLE_W-1:0]  w_x_nib;
    logic [NIBBLE_W-1:0]  w_y_nib;
    logic [NIBBLE_W-1:0]  w_bls_diff;
    logic                 w_bls_bout;

    // Present the current nibble of the latched operands to the shared slice.
    assign w_x_nib = x_q[cnt_q*NIBBLE_W +: NIBBLE_W];
    assign w_y_nib = y_q[cnt_q*NIBBLE_W +: NIBBLE_W];

    Lab2_4_bit_BLS_behavioral u_bls (
        .i_a    (w_x_nib),
        .i_b    (w_y_nib),
        .i_bin  (borrow_q),
        .o_diff (w_bls_diff),
        .o_bout (w_bls_bout)
    );

    // Next-state, datapath and flag computation; outputs are registered from
    // the same next values so busy/done line up with the state register.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        borrow_d = borrow_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // Accepting a request clears the previous result so no
                    // stale flags survive into the new operation.
                    x_d      = X;
                    y_d      = Y;
                    borrow_d = Bin;
                    cnt_d    = '0;
                    diff_d   = '0;
                    bout_d   = 1'b0;
                    zero_d   = 1'b0;
                    ovf_d    = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = ST_RUN;
                end else begin
                    state_d  = ST_IDLE;
                end
            end

            ST_RUN: begin
                diff_d[cnt_q*NIBBLE_W +: NIBBLE_W] = w_bls_diff;
                borrow_d = w_bls_bout;
                if (cnt_q == c_last_cnt) begin
                    // Flags use diff_d so the final nibble is included.
                    bout_d  = w_bls_bout;
                    zero_d  = (diff_d == '0);
                    ovf_d   = (x_q[WIDTH-1] ^ y_q[WIDTH-1])
                            & (diff_d[WIDTH-1] ^ x_q[WIDTH-1]);
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    busy_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, operand and result registers with synchronous reset priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            borrow_q <= borrow_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Diff = diff_q;
    assign Bout = bout_q;
    assign zero = zero_q;
    assign ovf  = ovf_q;

endmodule : serial_bls_sequencer
`default_nettype wire

// File: tb/tb_serial_bls_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_bls_sequencer
//  Description : Self-checking bench for serial_bls_sequencer. Directed cases
//                followed by randomized operations, compared against an
//                arithmetic reference model of X - Y - Bin.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_bls_sequencer;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
    logic             zero;
    logic             ovf;

    int checks = 0;
    int errors = 0;

    serial_bls_sequencer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .X     (X),
        .Y     (Y),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .Diff  (Diff),
        .Bout  (Bout),
        .zero  (zero),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    // Hard time limit so a stuck run still terminates.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed/unsigned integer arithmetic on the operands.
    task automatic model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic bin, output logic [WIDTH-1:0] d,
                         output logic bo, output logic z, output logic ov);
        longint ux, uy, full, sx, sy, sres, lmax, lmin;
        ux   = longint'(x);
        uy   = longint'(y);
        full = ux - uy - longint'(bin);
        d    = full[WIDTH-1:0];
        bo   = (full < 0);
        z    = (full[WIDTH-1:0] == '0);
        sx   = x[WIDTH-1] ? ux - (longint'(1) << WIDTH) : ux;
        sy   = y[WIDTH-1] ? uy - (longint'(1) << WIDTH) : uy;
        sres = sx - sy - longint'(bin);
        lmax = (longint'(1) << (WIDTH-1)) - 1;
        lmin = -(longint'(1) << (WIDTH-1));
        ov   = (sres > lmax) || (sres < lmin);
    endtask

    // Present a request for one cycle, then scramble the inputs.
    task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic bin);
        start = 1'b1;
        X = x; Y = y; Bin = bin;
        @(negedge clk);
        start = 1'b0;
        X = WIDTH'($urandom);
        Y = WIDTH'($urandom);
        Bin = 1'($urandom);
    endtask

    // Called on the first busy cycle. Checks RUN cycles, the done cycle, and
    // either the following idle cycle or a back-to-back request.
    task automatic check_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                            input logic bin, input int inject, input bit chain,
                            input logic [WIDTH-1:0] nx, input logic [WIDTH-1:0] ny,
                            input logic nbin);
        logic [WIDTH-1:0] ed, mask;
        logic eb, ez, eo;
        model(x, y, bin, ed, eb, ez, eo);
        for (int i = 0; i < NIB; i++) begin
            mask = '0;
            for (int j = 0; j < i; j++) mask[4*j +: 4] = 4'hF;
            chk("busy_run", busy, 1'b1);
            chk("done_run", done, 1'b0);
            chk("diff_prog", Diff, ed & mask);
            chk("bout_run", Bout, 1'b0);
            chk("zero_run", zero, 1'b0);
            chk("ovf_run", ovf, 1'b0);
            if (i == inject) begin
                start = 1'b1;
                X = '1; Y = '0; Bin = 1'b0;
            end
            @(negedge clk);
            start = 1'b0;
        end
        chk("done_pulse", done, 1'b1);
        chk("busy_done", busy, 1'b0);
        chk("diff", Diff, ed);
        chk("bout", Bout, eb);
        chk("zero", zero, ez);
        chk("ovf", ovf, eo);
        if (chain) begin
            issue(nx, ny, nbin);
        end else begin
            @(negedge clk);
            chk("done_after", done, 1'b0);
            chk("busy_after", busy, 1'b0);
            chk("diff_hold", Diff, ed);
            chk("bout_hold", Bout, eb);
            chk("zero_hold", zero, ez);
            chk("ovf_hold", ovf, eo);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] cx, cy, nx, ny;
        logic cb, nb, pending, chain;

        rst = 1'b1; start = 1'b0; X = '0; Y = '0; Bin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_diff", Diff, '0);
        chk("rst_bout", Bout, 1'b0);
        chk("rst_zero", zero, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Basic subtraction with multi-nibble borrow ripple.
        issue(16'h1234, 16'h0FFF, 1'b0);
        check_op(16'h1234, 16'h0FFF, 1'b0, -1, 1'b0, '0, '0, 1'b0);
        // Unsigned underflow and signed overflow.
        issue(16'h0000, 16'h0001, 1'b0);
        check_op(16'h0000, 16'h0001, 1'b0, -1, 1'b0, '0, '0, 1'b0);
        issue(16'h8000, 16'h0001, 1'b0);
        check_op(16'h8000, 16'h0001, 1'b0, -1, 1'b0, '0, '0, 1'b0);
        // Equal operands, with and without borrow-in.
        issue(16'h5A5A, 16'h5A5A, 1'b0);
        check_op(16'h5A5A, 16'h5A5A, 1'b0, -1, 1'b0, '0, '0, 1'b0);
        issue(16'h5A5A, 16'h5A5A, 1'b1);
        check_op(16'h5A5A, 16'h5A5A, 1'b1, -1, 1'b0, '0, '0, 1'b0);
        // Start pulsed mid-RUN must be ignored.
        issue(16'h0010, 16'h0001, 1'b0);
        check_op(16'h0010, 16'h0001, 1'b0, 1, 1'b0, '0, '0, 1'b0);

        // Reset in the third RUN cycle discards the operation.
        issue(16'h1111, 16'h0222, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_diff", Diff, '0);
        chk("abort_done", done, 1'b0);
        for (int k = 0; k < NIB + 2; k++) begin
            @(negedge clk);
            chk("abort_no_done", done, 1'b0);
        end
        issue(16'hABCD, 16'h1234, 1'b1);
        check_op(16'hABCD, 16'h1234, 1'b1, -1, 1'b0, '0, '0, 1'b0);

        // Back-to-back acceptance during the done cycle.
        issue(16'h7777, 16'h1111, 1'b0);
        check_op(16'h7777, 16'h1111, 1'b0, -1, 1'b1, 16'h0003, 16'h0004, 1'b0);
        check_op(16'h0003, 16'h0004, 1'b0, -1, 1'b0, '0, '0, 1'b0);

        // Randomized operations, some chained back-to-back.
        pending = 1'b0;
        cx = WIDTH'($urandom); cy = WIDTH'($urandom); cb = 1'($urandom);
        for (int k = 0; k < 24; k++) begin
            if (!pending) issue(cx, cy, cb);
            chain = 1'($urandom);
            nx = WIDTH'($urandom);
            ny = ($urandom_range(0, 3) == 0) ? nx : WIDTH'($urandom);
            nb = 1'($urandom);
            check_op(cx, cy, cb, -1, chain, nx, ny, nb);
            pending = chain;
            cx = nx; cy = ny; cb = nb;
        end
        if (pending) check_op(cx, cy, cb, -1, 1'b0, '0, '0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_bls_sequencer
`default_nettype wire
